// File: rtl/dds_pkg.sv
// Shared constants for the dds front-end controller and datapath.
// Waveform codes, controller FSM states and default word settings.
package dds_pkg;

  localparam logic [1:0] WAVE_SINE   = 2'd0;
  localparam logic [1:0] WAVE_SQUARE = 2'd1;
  localparam logic [1:0] WAVE_TRI    = 2'd2;
  localparam logic [1:0] WAVE_SAW    = 2'd3;

  localparam int unsigned FW_WIDTH_DEF = 32;
  localparam int unsigned PW_WIDTH_DEF = 12;
  localparam int unsigned TMO_WIDTH    = 24;

  localparam logic [31:0] FW_INIT_DEF = 32'd85_899;
  localparam logic [31:0] FW_STEP_DEF = 32'd85_899;
  localparam logic [31:0] FW_MIN_DEF  = 32'd85_899;
  localparam logic [31:0] FW_MAX_DEF  = 32'd858_993_459;
  localparam logic [11:0] PW_STEP_DEF = 12'd1024;

  localparam logic [TMO_WIDTH-1:0] WRAP_TIMEOUT_DEF = 24'd12_499_999;

  typedef enum logic {
    StIdle,
    StPend
  } ctrl_state_e;

endpackage

// File: rtl/dds_ctrl_if.sv
// Key/wrap inputs and applied configuration outputs of the dds controller.
interface dds_ctrl_if #(
  parameter int unsigned FW_WIDTH = 32,
  parameter int unsigned PW_WIDTH = 12
);
  logic [3:0]          key_in;
  logic                phase_wrap;
  logic [1:0]          wave_sel;
  logic [FW_WIDTH-1:0] freq_word;
  logic [PW_WIDTH-1:0] phase_word;
  logic                cfg_upd;

  modport master (
    output key_in, phase_wrap,
    input  wave_sel, freq_word, phase_word, cfg_upd
  );

  modport slave (
    input  key_in, phase_wrap,
    output wave_sel, freq_word, phase_word, cfg_upd
  );
endinterface

// File: rtl/key_filter.sv
// Single active-low key: 2-flop synchroniser, saturating debounce counter and
// a one-cycle press pulse when the counter reaches CNT_DEBOUNCE.
module key_filter #(
  parameter int unsigned CNT_DEBOUNCE = 999_999
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CntW = $clog2(CNT_DEBOUNCE + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(CNT_DEBOUNCE);
  localparam logic [CntW-1:0] CntArm = CntW'(CNT_DEBOUNCE - 1);

  logic            key_s1_q, key_s2_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      key_s1_q <= key_n;
      key_s2_q <= key_s1_q;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (key_s2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Fires only on the step into saturation, so a held key pulses once.
  assign press = !key_s2_q && (cnt_q == CntArm);

endmodule

// File: rtl/dds_ctrl.sv
// Key-driven configuration controller: presses edit shadow registers, which are
// applied to the dds outputs together at a phase wrap or after a timeout.
module dds_ctrl
  import dds_pkg::*;
#(
  parameter int unsigned          CNT_DEBOUNCE = 999_999,
  parameter int unsigned          FW_WIDTH     = FW_WIDTH_DEF,
  parameter logic [FW_WIDTH-1:0]  FW_INIT      = FW_WIDTH'(FW_INIT_DEF),
  parameter logic [FW_WIDTH-1:0]  FW_STEP      = FW_WIDTH'(FW_STEP_DEF),
  parameter logic [FW_WIDTH-1:0]  FW_MIN       = FW_WIDTH'(FW_MIN_DEF),
  parameter logic [FW_WIDTH-1:0]  FW_MAX       = FW_WIDTH'(FW_MAX_DEF),
  parameter int unsigned          PW_WIDTH     = PW_WIDTH_DEF,
  parameter logic [PW_WIDTH-1:0]  PW_STEP      = PW_WIDTH'(PW_STEP_DEF),
  parameter logic [TMO_WIDTH-1:0] WRAP_TIMEOUT = WRAP_TIMEOUT_DEF
) (
  input logic       sys_clk,
  input logic       sys_rst,
  dds_ctrl_if.slave bus
);

  logic [3:0] press;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_filter #(
      .CNT_DEBOUNCE(CNT_DEBOUNCE)
    ) u_key_filter (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .key_n  (bus.key_in[i]),
      .press  (press[i])
    );
  end

  ctrl_state_e          state_q, state_d;
  logic [TMO_WIDTH-1:0] tmo_q, tmo_d;
  logic                 apply;

  logic [1:0]          wave_sh_q, wave_sh_d, wave_q;
  logic [FW_WIDTH-1:0] fw_sh_q, fw_sh_d, fw_q;
  logic [PW_WIDTH-1:0] pw_sh_q, pw_sh_d, pw_q;
  logic                cfg_upd_q;
  logic [FW_WIDTH:0]   fw_sum, fw_diff;

  // Shadow edits; one extra bit carries the overflow/borrow for saturation.
  always_comb begin
    wave_sh_d = wave_sh_q;
    fw_sh_d   = fw_sh_q;
    pw_sh_d   = pw_sh_q;
    fw_sum    = {1'b0, fw_sh_q} + {1'b0, FW_STEP};
    fw_diff   = {1'b0, fw_sh_q} - {1'b0, FW_STEP};
    if (press[0]) wave_sh_d = wave_sh_q + 2'd1;
    if (press[3]) pw_sh_d = pw_sh_q + PW_STEP;
    if (press[1] && !press[2]) begin
      fw_sh_d = (fw_sum > {1'b0, FW_MAX}) ? FW_MAX : fw_sum[FW_WIDTH-1:0];
    end else if (press[2] && !press[1]) begin
      fw_sh_d = (fw_diff[FW_WIDTH] || (fw_diff[FW_WIDTH-1:0] < FW_MIN)) ?
                FW_MIN : fw_diff[FW_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    apply   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|press) begin
          state_d = StPend;
          tmo_d   = '0;
        end
      end
      StPend: begin
        if (bus.phase_wrap || (tmo_q == WRAP_TIMEOUT)) begin
          apply   = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TMO_WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= StIdle;
      tmo_q     <= '0;
      wave_sh_q <= WAVE_SINE;
      fw_sh_q   <= FW_INIT;
      pw_sh_q   <= '0;
      wave_q    <= WAVE_SINE;
      fw_q      <= FW_INIT;
      pw_q      <= '0;
      cfg_upd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      wave_sh_q <= wave_sh_d;
      fw_sh_q   <= fw_sh_d;
      pw_sh_q   <= pw_sh_d;
      cfg_upd_q <= apply;
      // Load the post-edit shadows so a same-cycle press is included.
      if (apply) begin
        wave_q <= wave_sh_d;
        fw_q   <= fw_sh_d;
        pw_q   <= pw_sh_d;
      end
    end
  end

  assign bus.wave_sel   = wave_q;
  assign bus.freq_word  = fw_q;
  assign bus.phase_word = pw_q;
  assign bus.cfg_upd    = cfg_upd_q;

endmodule
